// File: rtl/vga_frame_sink.sv
// 320x240x3 framebuffer with single-pixel write port, scanned out pixel-doubled as 640x480@60 VGA.
// Optional build macro VGA_BORDER_EN draws a white one-pixel frame around the visible area.
module vga_frame_sink #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC_W = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [2:0] color,
  input  logic       writeEn,
  output logic       V_SYNC,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam logic [9:0]  H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_VIS + V_FP + V_SYNC_W + V_BP - 1);
  localparam logic [9:0]  HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC_W);
  localparam logic [9:0]  H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_W  = 10'(V_VIS);
  localparam int          FB_DEPTH = 76800;

  // Each 3-bit color channel bit drives a full 8-bit DAC channel.
  function automatic logic [23:0] expand_rgb(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  logic        pe_r;
  logic [9:0]  hcnt_r;
  logic [9:0]  vcnt_r;
  logic        hs_d_r;
  logic        vs_d_r;
  logic        vis_d_r;
  logic        hs_r;
  logic        vs_r;
  logic        blank_n_r;
  logic [23:0] rgb_r;
  logic [2:0]  rd_data_r;
  logic [2:0]  fb_mem_r [0:FB_DEPTH-1];

  logic        hs_raw_s;
  logic        vs_raw_s;
  logic        vis_raw_s;
  logic [16:0] rd_addr_s;
  logic [16:0] wr_addr_s;
  logic        wr_en_s;
  logic [23:0] pix_s;

  assign hs_raw_s  = ~((hcnt_r >= HS_FIRST) && (hcnt_r < HS_END));
  assign vs_raw_s  = ~((vcnt_r >= VS_FIRST) && (vcnt_r < VS_END));
  assign vis_raw_s = (hcnt_r < H_VIS_W) && (vcnt_r < V_VIS_W);

  // Row*320 built from two shifts so no multiplier is inferred.
  assign rd_addr_s = ({8'd0, vcnt_r[9:1]} << 8) + ({8'd0, vcnt_r[9:1]} << 6) + {8'd0, hcnt_r[9:1]};
  assign wr_addr_s = ({9'd0, y} << 8) + ({9'd0, y} << 6) + {8'd0, x};
  assign wr_en_s   = ~iReset & writeEn & (x < 9'd320) & (y < 8'd240);

`ifdef VGA_BORDER_EN
  logic border_raw_s;
  logic border_d_r;

  assign border_raw_s = (hcnt_r == 10'd0) || (hcnt_r == H_VIS_W - 10'd1) ||
                        (vcnt_r == 10'd0) || (vcnt_r == V_VIS_W - 10'd1);

  // Border flag rides the same delay stage as the RAM read data.
  always_ff @(posedge clk) begin
    if (iReset) begin
      border_d_r <= 1'b0;
    end else if (pe_r) begin
      border_d_r <= border_raw_s;
    end
  end
`endif

  // Framebuffer write port, any clk cycle.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      fb_mem_r[wr_addr_s] <= color;
    end
  end

  // Framebuffer read port; a same-edge write is not visible until the next read.
  always_ff @(posedge clk) begin
    if (pe_r) begin
      rd_data_r <= fb_mem_r[rd_addr_s];
    end
  end

  // Output color selection for the delayed pixel.
  always_comb begin
    if (!vis_d_r) begin
      pix_s = 24'd0;
`ifdef VGA_BORDER_EN
    end else if (border_d_r) begin
      pix_s = 24'hFF_FFFF;
`endif
    end else begin
      pix_s = expand_rgb(rd_data_r);
    end
  end

  // Pixel enable, scan counters and the two-tick sync/blank/color pipeline.
  always_ff @(posedge clk) begin
    if (iReset) begin
      pe_r      <= 1'b0;
      hcnt_r    <= 10'd0;
      vcnt_r    <= 10'd0;
      hs_d_r    <= 1'b1;
      vs_d_r    <= 1'b1;
      vis_d_r   <= 1'b0;
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_n_r <= 1'b0;
      rgb_r     <= 24'd0;
    end else begin
      pe_r <= ~pe_r;
      if (pe_r) begin
        if (hcnt_r == H_LAST) begin
          hcnt_r <= 10'd0;
          vcnt_r <= (vcnt_r == V_LAST) ? 10'd0 : vcnt_r + 10'd1;
        end else begin
          hcnt_r <= hcnt_r + 10'd1;
        end
        hs_d_r    <= hs_raw_s;
        vs_d_r    <= vs_raw_s;
        vis_d_r   <= vis_raw_s;
        hs_r      <= hs_d_r;
        vs_r      <= vs_d_r;
        blank_n_r <= vis_d_r;
        rgb_r     <= pix_s;
      end
    end
  end

  assign V_SYNC      = vs_r;
  assign VGA_VS      = vs_r;
  assign VGA_HS      = hs_r;
  assign VGA_CLK     = pe_r;
  assign VGA_BLANK_N = blank_n_r;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = rgb_r[23:16];
  assign VGA_G       = rgb_r[15:8];
  assign VGA_B       = rgb_r[7:0];

endmodule

// File: tb/tb_vga_frame_sink.sv
// Randomized bench for vga_frame_sink with a position-based reference model of the scan-out.
module tb_vga_frame_sink;

  logic       clk;
  logic       iReset;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic       writeEn;
  logic       V_SYNC, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_frame_sink dut (
    .clk(clk), .iReset(iReset), .x(x), .y(y), .color(color), .writeEn(writeEn),
    .V_SYNC(V_SYNC), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int check_count = 0;
  int error_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got !== want) begin
      error_count++;
      if (error_count <= 30)
        $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: screen position counted in pixel ticks since reset.
  logic [2:0]  m_fb [0:76799];
  logic        m_pe;
  int          m_pos;
  logic [26:0] m_stage, m_out;
  int          m_stage_h, m_stage_v, m_out_h, m_out_v;
  logic        check_en;
  int          phase;
  localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'd0};

  function automatic logic [26:0] expect_at(input int pos);
    int h, v;
    logic hs, vs, vis;
    logic [2:0] c;
    logic [23:0] rgb;
    h = pos % 800;
    v = pos / 800;
    hs = !(h >= 656 && h <= 751);
    vs = !(v >= 490 && v <= 491);
    vis = (h < 640) && (v < 480);
    c = 3'd0;
    if (vis) c = m_fb[(v / 2) * 320 + h / 2];
    rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
`ifdef VGA_BORDER_EN
    if (vis && (h == 0 || h == 639 || v == 0 || v == 479)) rgb = 24'hFFFFFF;
`endif
    return {hs, vs, vis, rgb};
  endfunction

  task automatic directed(input int h, input int v, input int ph, input string tag, input logic [23:0] want);
    if (m_out_h == h && m_out_v == v && (ph == 0 || ph == phase))
      check_eq(tag, {VGA_R, VGA_G, VGA_B}, want);
  endtask

  task automatic step();
    @(posedge clk);
    if (iReset) begin
      m_pe = 1'b0; m_pos = 0;
      m_stage = IDLE; m_out = IDLE;
      m_stage_h = -1; m_stage_v = -1; m_out_h = -1; m_out_v = -1;
    end else begin
      if (m_pe) begin
        m_out = m_stage; m_out_h = m_stage_h; m_out_v = m_stage_v;
        m_stage = expect_at(m_pos);
        m_stage_h = m_pos % 800; m_stage_v = m_pos / 800;
        m_pos = (m_pos + 1) % 420000;
      end
      m_pe = !m_pe;
      if (writeEn && x < 9'd320 && y < 8'd240) m_fb[int'(y) * 320 + int'(x)] = color;
    end
    @(negedge clk);
    if (check_en) begin
      check_eq("pixel", {5'd0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {5'd0, m_out});
      check_eq("vsync_out", {31'd0, V_SYNC}, {31'd0, m_out[25]});
      check_eq("vga_clk", {31'd0, VGA_CLK}, {31'd0, m_pe});
      check_eq("sync_n", {31'd0, VGA_SYNC_N}, 32'd0);
`ifdef VGA_BORDER_EN
      directed(0, 0, 0, "border_00", 24'hFFFFFF);
      directed(639, 2, 0, "border_639", 24'hFFFFFF);
      directed(320, 1, 0, "inner_black", 24'h000000);
      directed(10, 6, 1, "px_10_6", 24'hFF00FF);
`else
      directed(0, 0, 1, "collide_old", 24'h000000);
      directed(0, 0, 2, "collide_new", 24'h00FF00);
      directed(10, 6, 1, "px_10_6", 24'hFF00FF);
      directed(11, 6, 1, "px_11_6", 24'hFF00FF);
      directed(10, 7, 1, "px_10_7", 24'hFF00FF);
      directed(11, 7, 1, "px_11_7", 24'hFF00FF);
      directed(12, 6, 1, "px_12_6", 24'h000000);
      directed(10, 8, 1, "px_10_8", 24'h000000);
      directed(0, 2, 0, "no_alias_0_1", 24'h000000);
      directed(639, 2, 1, "edge_black", 24'h000000);
`endif
    end
  endtask

  task automatic wr(input int wx, input int wy, input logic [2:0] c);
    writeEn = 1'b1; x = 9'(wx); y = 8'(wy); color = c;
    step();
    writeEn = 1'b0;
  endtask

  initial begin
    int n, w;
    for (int i = 0; i < 76800; i++) m_fb[i] = 3'd0;
    check_en = 1'b0; phase = 0;
    iReset = 1'b1; writeEn = 1'b0; x = 9'd0; y = 8'd0; color = 3'd0;
    repeat (3) step();
    iReset = 1'b0;
    for (int r = 0; r < 25; r++)
      for (int c = 0; c < 320; c++) wr(c, r, 3'd0);

    check_en = 1'b1;
    iReset = 1'b1;
    repeat (3) step();
    phase = 1;
    iReset = 1'b0;
    step();
    wr(0, 0, 3'b010);
    wr(5, 3, 3'b101);
    wr(320, 0, 3'b111);
    wr(0, 240, 3'b111);
    for (int i = 0; i < 32000; i++) begin
      writeEn = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: begin x = 9'($urandom_range(320, 511)); y = 8'($urandom_range(0, 255)); end
        1: begin x = 9'($urandom_range(0, 319)); y = 8'($urandom_range(240, 255)); end
        default: begin x = 9'($urandom_range(8, 40)); y = 8'($urandom_range(0, 14)); end
      endcase
      color = 3'($urandom_range(0, 7));
      step();
    end
    writeEn = 1'b0;

    iReset = 1'b1;
    step();
    check_eq("rst_hs", {31'd0, VGA_HS}, 32'd1);
    check_eq("rst_vs", {31'd0, VGA_VS}, 32'd1);
    check_eq("rst_vsync", {31'd0, V_SYNC}, 32'd1);
    check_eq("rst_blank", {31'd0, VGA_BLANK_N}, 32'd0);
    check_eq("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check_eq("rst_vclk", {31'd0, VGA_CLK}, 32'd0);
    repeat (2) step();
    phase = 2;
    iReset = 1'b0;

    n = 0;
    while (n < 5000 && !(n > 0 && VGA_HS == 1'b0)) begin step(); n++; end
    check_eq("hs_first_fall", n, 1316);
    w = 0;
    while (w < 5000 && VGA_HS == 1'b0) begin step(); w++; end
    check_eq("hs_low_width", w, 192);
    n = w;
    while (n < 5000 && VGA_HS == 1'b1) begin step(); n++; end
    check_eq("hs_period", n, 1600);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
